// File: rtl/pipe_seq_ctrl_pkg.sv
// Purpose : shared types for the pipeline sequencer (FSM state, per-buffer control bundle).
// Latency : n/a (types and constants only).
// Backpr. : n/a; the bundle carries the enables that stall each pipeline buffer.
package pipe_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } seq_state_e;

    // One enable/flush pair per pipeline register, plus the PC load enable.
    // Flush wins over enable inside each buffer register.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic exmem_flush;
        logic memwb_en;
        logic memwb_flush;
    } pipe_ctrl_t;

    // Everything frozen and cleared: used while reset is held.
    localparam pipe_ctrl_t CTRL_RESET = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1,
                                          idex_en: 1'b0, idex_flush: 1'b1,
                                          exmem_en: 1'b0, exmem_flush: 1'b1,
                                          memwb_en: 1'b0, memwb_flush: 1'b1};
    // Free-running pipeline.
    localparam pipe_ctrl_t CTRL_RUN = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                        idex_en: 1'b1, idex_flush: 1'b0,
                                        exmem_en: 1'b1, exmem_flush: 1'b0,
                                        memwb_en: 1'b1, memwb_flush: 1'b0};
    // Load-use: hold PC and IF/ID, drop a bubble into ID/EX, let older work advance.
    localparam pipe_ctrl_t CTRL_LOAD_USE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                             idex_en: 1'b1, idex_flush: 1'b1,
                                             exmem_en: 1'b1, exmem_flush: 1'b0,
                                             memwb_en: 1'b1, memwb_flush: 1'b0};
    // Redirect: PC takes the target, the two wrong-path instructions are squashed.
    localparam pipe_ctrl_t CTRL_REDIRECT = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
                                             idex_en: 1'b1, idex_flush: 1'b1,
                                             exmem_en: 1'b1, exmem_flush: 1'b0,
                                             memwb_en: 1'b1, memwb_flush: 1'b0};
    // Drain: stop fetching, squash the front end, let MEM and WB empty out.
    localparam pipe_ctrl_t CTRL_DRAIN = '{pc_en: 1'b0, ifid_en: 1'b1, ifid_flush: 1'b1,
                                          idex_en: 1'b1, idex_flush: 1'b1,
                                          exmem_en: 1'b1, exmem_flush: 1'b0,
                                          memwb_en: 1'b1, memwb_flush: 1'b0};
    // Data-memory wait: freeze everything up to EX/MEM; WB retires its instruction
    // and MEM/WB takes a bubble so the write is not repeated.
    localparam pipe_ctrl_t CTRL_MEM_STALL = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                              idex_en: 1'b0, idex_flush: 1'b0,
                                              exmem_en: 1'b0, exmem_flush: 1'b0,
                                              memwb_en: 1'b1, memwb_flush: 1'b1};
    // Halted: nothing moves.
    localparam pipe_ctrl_t CTRL_HALT = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                         idex_en: 1'b0, idex_flush: 1'b0,
                                         exmem_en: 1'b0, exmem_flush: 1'b0,
                                         memwb_en: 1'b0, memwb_flush: 1'b0};

endpackage

// File: rtl/pipe_seq_ctrl_load_use_detect.sv
// Purpose : flags a load in EX whose destination is a source of the instruction in ID.
// Latency : purely combinational, same cycle.
// Backpr. : none; the sequencer decides whether the hazard actually stalls.
// Ports   : ex_memread/ex_rd (ID/EX load info), id_rs1/id_rs2 (ID sources) -> hazard.
module load_use_detect (
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       hazard
);

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign hazard = ex_memread && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Purpose : 5-stage pipeline sequencer: PC/buffer enables+flushes, HALT drain, stall counter, dmem watchdog.
// Latency : control outputs are combinational from state and current inputs (0 cycles).
// Backpr. : dmem wait freezes PC..EX/MEM and bubbles MEM/WB; load-use holds PC and IF/ID.
// Ports   : hazard inputs from ID/EX/MEM -> pc_en, <buf>_en/<buf>_flush, halted, mem_timeout, stall_cnt.
module pipe_seq_ctrl
    import pipe_seq_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 255,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             ex_halt,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int DRN_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

    seq_state_e        state_q, state_d;
    logic [DRN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              timeout_q;

    pipe_ctrl_t        ctrl;
    logic              lu_hazard;
    logic              mem_stall;
    logic              timeout_hit;
    logic              count_stall;
    logic              set_timeout;

    load_use_detect u_load_use_detect (
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .hazard     (lu_hazard)
    );

    assign mem_stall   = mem_req && !mem_ready;
    // Last tolerated wait cycle: if memory is still not ready now, give up.
    assign timeout_hit = mem_stall && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        wait_cnt_d  = '0;
        ctrl        = CTRL_RUN;
        count_stall = 1'b0;
        set_timeout = 1'b0;

        unique case (state_q)
            RUN, DRAIN: begin
                if (mem_stall) begin
                    // Memory wait dominates; other hazards are re-evaluated once it clears.
                    ctrl        = CTRL_MEM_STALL;
                    count_stall = 1'b1;
                    wait_cnt_d  = wait_cnt_q + WAIT_W'(1);
                    if (timeout_hit) begin
                        set_timeout = 1'b1;
                        state_d     = HALTED;
                    end
                end else if (state_q == DRAIN) begin
                    ctrl        = CTRL_DRAIN;
                    drain_cnt_d = drain_cnt_q - DRN_W'(1);
                    if (drain_cnt_q <= DRN_W'(1)) begin
                        state_d = HALTED;
                    end
                end else if (ex_halt) begin
                    ctrl        = CTRL_DRAIN;
                    drain_cnt_d = DRN_W'(DRAIN_CYCLES);
                    state_d     = DRAIN;
                end else if (ex_redirect) begin
                    // The instruction in ID is squashed, so a load-use bubble would be wasted.
                    ctrl = CTRL_REDIRECT;
                end else if (lu_hazard) begin
                    ctrl        = CTRL_LOAD_USE;
                    count_stall = 1'b1;
                end
            end
            HALTED: begin
                ctrl = CTRL_HALT;
            end
            default: begin
                ctrl    = CTRL_HALT;
                state_d = RUN;
            end
        endcase

        if (reset) begin
            ctrl = CTRL_RESET;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            if (count_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign pc_en       = ctrl.pc_en;
    assign ifid_en     = ctrl.ifid_en;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_en     = ctrl.idex_en;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_en    = ctrl.exmem_en;
    assign exmem_flush = ctrl.exmem_flush;
    assign memwb_en    = ctrl.memwb_en;
    assign memwb_flush = ctrl.memwb_flush;

    assign halted      = (state_q == HALTED);
    assign mem_timeout = timeout_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: doc/pipe_seq_ctrl.md
Name: pipe_seq_ctrl

Overview:
Pipeline sequencer for the 5-stage RV32 core.
- Drives enable/flush for PC and the four pipeline buffer registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Resolves load-use stalls, taken-branch/jump flushes and data-memory wait stalls.
- Runs the HALT drain sequence.
- Keeps a stall-cycle performance counter and a data-memory timeout watchdog.

Parameters:
MEM_TIMEOUT, 255, max consecutive dmem wait cycles before a fatal timeout
DRAIN_CYCLES, 2, cycles from HALT leaving EX until pipeline empty (MEM, WB)
CNT_W, 16, width of stall counter

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
id_rs1  in  5  RS_One of instruction in ID
id_rs2  in  5  RS_Two of instruction in ID
ex_memread  in  1  ID/EX MemRead
ex_rd  in  5  ID/EX rd
ex_redirect  in  1  branch taken or Jump/JALR resolved in EX
ex_halt  in  1  ID/EX Halt
mem_req  in  1  EX/MEM MemRead|MemWrite
mem_ready  in  1  data memory ready for current request
pc_en  out  1  PC register load enable
ifid_en / ifid_flush  out  1 / 1  IF/ID enable, zero-bubble insert
idex_en / idex_flush  out  1 / 1  ID/EX enable, bubble insert
exmem_en / exmem_flush  out  1 / 1  EX/MEM enable, bubble insert
memwb_en / memwb_flush  out  1 / 1  MEM/WB enable, bubble insert
halted  out  1  core halted, pipeline empty
mem_timeout  out  1  sticky fatal dmem timeout
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- FSM states: RUN, DRAIN, HALTED. Reset → RUN; drain_cnt=0, wait_cnt=0, stall_cnt=0, halted=0, mem_timeout=0.
- While reset is high, outputs are: all *_en=0, all *_flush=1.
- All control outputs are combinational from state plus the current-cycle inputs; no added latency.
- Flush takes priority over enable in the target register; a flushed register loads all-zero (NOP, all control bits 0).
- mem_stall = mem_req & ~mem_ready.
  - Any state except HALTED: pc_en=ifid_en=idex_en=exmem_en=0, memwb_en=1, memwb_flush=1.
  - The older instruction in WB completes; no duplicate write.
  - Every other hazard is ignored this cycle and re-evaluated after release.
- wait_cnt increments on each mem_stall cycle and clears on any non-stall cycle.
  - On the cycle wait_cnt == MEM_TIMEOUT-1 with mem_stall still high: set mem_timeout and go to HALTED.
- RUN, no mem_stall, priority: ex_halt > ex_redirect > load-use.
  - ex_halt: pc_en=0, ifid_flush=1, idex_flush=1, exmem_en=1, memwb_en=1. Load drain_cnt=DRAIN_CYCLES, go to DRAIN.
  - ex_redirect: pc_en=1 (target loads), ifid_flush=1, idex_flush=1, rest enabled.
  - load-use = ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2): pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1.
  - Otherwise all enables=1, all flushes=0.
- DRAIN:
  - pc_en=0, ifid_flush=1, idex_flush=1, exmem/memwb enabled.
  - drain_cnt decrements on each non-mem_stall cycle and holds during mem_stall.
  - drain_cnt reaches 1 on a non-stall cycle → HALTED next cycle.
- HALTED: all *_en=0, flushes=0, halted=1. Exit only by reset.
- stall_cnt increments each cycle with (load-use taken) | mem_stall, in RUN or DRAIN. It saturates at all-ones and does not count in HALTED.
- A redirect with rd hazard: the redirect wins; the load-use bubble is not inserted.
- Reset asserted mid-drain or mid-stall: state, all counters and flags return to reset values on the next edge.

Decomposition:
- Pipe_Buf_Reg_PKG additions:
  - seq_state_e enum (RUN, DRAIN, HALTED).
  - packed struct pipe_ctrl_t bundling the en/flush pairs, so the top level can drive the buffers with one signal.
- One combinational sub-module, load_use_detect: inputs ex_memread, ex_rd, id_rs1, id_rs2; output hazard.

Test Plan:
- ex_memread=1, ex_rd=5, id_rs1=5, one cycle → pc_en=0, ifid_en=0, idex_flush=1, stall_cnt 0→1. Same with ex_rd=0 → no stall.
- ex_redirect=1 together with the load-use condition → ifid_flush=idex_flush=1, pc_en=1, stall_cnt unchanged.
- mem_req=1, mem_ready low 3 cycles → pc/ifid/idex/exmem_en=0 and memwb_flush=1 for exactly 3 cycles, stall_cnt +=3. Full enable on the 4th cycle.
- ex_halt=1 → DRAIN. With one mem_stall cycle injected, halted rises 4 cycles after ex_halt (2 + 1 stall + 1). All enables 0 afterwards.
- MEM_TIMEOUT=4, mem_ready held low → mem_timeout=1 and halted=1 after the 4th stall cycle. Both remain set until reset.
- Reset pulse during DRAIN → state RUN, halted=0, stall_cnt=0, all enables 1 on the first cycle after reset.
